or1200_wb_arb: RTL
==================

# or1200_wb_arb

Two-master, one-slave Wishbone classic arbiter that lets the OR1200 instruction (IWB) and data (DWB) bus interfaces share a single external memory/peripheral bus. It sits between `or1200_top`'s `iwb_*`/`dwb_*` ports and the system slave bus. It grants ownership per bus cycle (`cyc`) with round-robin tie-breaking, including held CAB bursts. A watchdog terminates hung transfers with an error.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width; select width is `DW/8`.
- `TO_W`, 8: watchdog counter width; the timeout is `2**TO_W-1` cycles.

- `clk_i` in 1: bus clock.
- `rst_i` in 1: asynchronous, active-low reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: instruction master (IWB) control.
- `m0_sel_i` in DW/8, `m0_adr_i` in AW, `m0_dat_i` in DW: IWB select, address and write data.
- `m0_dat_o` out DW, `m0_ack_o`, `m0_err_o`, `m0_rty_o` out 1 each: IWB read data and termination.
- `m1_*`: data master (DWB), with the same set and widths as `m0_*`.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1, `s_sel_o` out DW/8, `s_adr_o` out AW, `s_dat_o` out DW: slave side.
- `s_dat_i` in DW, `s_ack_i`, `s_err_i`, `s_rty_i` in 1: slave read data and termination.
- `gnt_o` out 2: one-hot current owner; bit0 = m0, bit1 = m1, 00 = idle.

## Operation
- State machine: IDLE, GNT0, GNT1.
- The `last` register records the most recent owner. Its reset value is 0 (m0).
- **IDLE**
  - Only m0 has `cyc` high → go to GNT0.
  - Only m1 has `cyc` high → go to GNT1.
  - Both have `cyc` high → grant the master that is not `last`.
  - `last` updates on every grant.
- **GNTx**
  - Hold while `mx_cyc_i` is 1, regardless of the other master. Bursts and RMW sequences are never split.
  - When `mx_cyc_i` is 0 → return to IDLE.
  - `cyc` and `stb` dropping together with a final `ack` is legal.
- **Forward path** (combinational from state)
  - In GNTx, every `s_*_o` equals the corresponding `mx_*_i`.
  - In IDLE, all `s_*_o` are 0.
- **Return path**
  - `s_dat_i` is broadcast to both `m0_dat_o` and `m1_dat_o`.
  - `ack`, `err` and `rty` are routed only to the granted master. The non-granted master always sees 0.
- **Watchdog**
  - `wdt` is `TO_W` bits wide.
  - It increments each cycle in which the state is GNTx, `mx_stb_i` is 1, and none of `s_ack_i`/`s_err_i`/`s_rty_i` is 1.
  - It clears on any termination, on `stb` low, or in IDLE.
  - When `wdt == 2**TO_W-1`, for that one cycle:
    - `mx_err_o` = 1 and `mx_ack_o` = 0, even if `s_ack_i` rises in the same cycle;
    - `s_cyc_o` and `s_stb_o` are forced to 0;
    - `wdt` clears on the next edge.
  - Grant is not revoked by the watchdog; the master ends the cycle normally.
- Simultaneous `s_ack_i` and `s_err_i`: both are forwarded unmodified. The master's priority rules apply.
- Reset asserted mid-transfer: the state goes immediately to IDLE. All slave outputs and master terminations go to 0 with no clock required. The in-flight transfer is abandoned.

## Timing
- Reset values:
  - state = IDLE, `last` = 0, `wdt` = 0;
  - `gnt_o` = 00;
  - all `s_*_o` = 0;
  - all `mx_ack_o`, `mx_err_o`, `mx_rty_o` = 0;
  - `mx_dat_o` = `s_dat_i`.
- Grant latency: a `cyc` rising in IDLE during cycle N is presented on the slave from cycle N+1.
- `gnt_o` is registered and changes at the same edge as the state.
- Release: `mx_cyc_i` is 0 in cycle M → IDLE in M+1. Exactly one dead cycle separates two owners. A pending master is granted at the end of M+1 and drives the slave from M+2.
- Termination latency: 0 cycles. Slave termination passes combinationally to the owner in the same cycle.
- Watchdog `err` fires exactly `2**TO_W-1` stalled cycles after `stb` is first seen without termination.
- The design is fully synchronous to `clk_i` except for the asynchronous reset.

## Test plan
- **Single master:** m1 reads address 0x100, slave acks after 2 wait states → `gnt_o`=10 one cycle after `cyc`; `m1_ack_o` is high for 1 cycle with `m1_dat_o` = slave data; `m0_ack_o` stays 0.
- **Tie after reset:** m0 and m1 both raise `cyc` in the same cycle → m1 is granted first (`last`=0). After m1 drops `cyc`, one idle cycle follows, then `gnt_o`=01. A third simultaneous tie goes to m1.
- **Burst hold:** m0 holds `cyc` for a 4-beat CAB burst while m1 requests → all 4 acks go to m0 with `gnt_o` held at 01. m1 is granted 2 cycles after m0's `cyc` falls.
- **Watchdog:** TO_W=4 and the slave never acks m1's write → `m1_err_o`=1 at stalled cycle 15, with `s_cyc_o`/`s_stb_o` low that cycle. The slave's `ack` injected in the same cycle is suppressed.
- **Reset mid-op:** `rst_i` goes low during an m0 wait state → `s_cyc_o`, `gnt_o` and `m0_ack_o` drop to 0 asynchronously. After `rst_i` goes high, a new m0 request is granted with 1-cycle latency.
- **Retry passthrough:** the slave asserts `s_rty_i` to m0 → `m0_rty_o`=1 in the same cycle, `m1_rty_o`=0, and `wdt` clears.

Source files
------------

// File: rtl/or1200_wb_arb.sv
// -----------------------------------------------------------------------------
// or1200_wb_arb
//
// Purpose:
//   Two-master / one-slave Wishbone classic arbiter that lets the OR1200
//   instruction bus (m0 = IWB) and data bus (m1 = DWB) share one external
//   slave bus. Ownership is granted per bus cycle (cyc) and held until the
//   owner drops cyc, so CAB bursts and read-modify-write sequences are never
//   split. Simultaneous requests from idle are broken round-robin against the
//   most recent owner. A watchdog terminates a stalled strobe with an error.
//
// Parameters:
//   AW    address width
//   DW    data width (select width is DW/8)
//   TO_W  watchdog counter width; a strobe stalled for 2**TO_W-1 cycles is
//         terminated with err
//
// Ports:
//   clk_i, rst_i                 bus clock, asynchronous active-low reset
//   m0_*_i / m1_*_i              master requests (cyc, stb, we, sel, adr, dat)
//   m0_*_o / m1_*_o              read data (broadcast) and terminations
//                                (ack, err, rty; owner only)
//   s_*_o                        slave request, copied from the owner
//   s_dat_i, s_ack_i, s_err_i,
//   s_rty_i                      slave read data and terminations
//   gnt_o                        registered one-hot owner (bit0 m0, bit1 m1)
// -----------------------------------------------------------------------------
module or1200_wb_arb #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int TO_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,

  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,

  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,

  output logic [1:0]      gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            last, last_nxt;
  logic [TO_W-1:0] wdt;
  logic            own_stb;
  logic            any_term;
  logic            wdt_hit;

  // State, last owner and the registered grant all move on the same edge,
  // so gnt_o always mirrors the state that drives the forward path.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      last  <= 1'b0;
      gnt_o <= 2'b00;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      gnt_o <= {state_nxt == GNT1, state_nxt == GNT0};
    end
  end

  // A grant is only decided from IDLE; on a tie the master that did not own
  // the bus last wins. An owner keeps the bus for as long as it holds cyc.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = last ? GNT0 : GNT1;
          last_nxt  = ~last;
        end else if (m0_cyc_i) begin
          state_nxt = GNT0;
          last_nxt  = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt = GNT1;
          last_nxt  = 1'b1;
        end
      end
      GNT0: if (!m0_cyc_i) state_nxt = IDLE;
      GNT1: if (!m1_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign own_stb  = ((state == GNT0) && m0_stb_i) || ((state == GNT1) && m1_stb_i);
  assign any_term = s_ack_i || s_err_i || s_rty_i;
  // Gated by the owner's strobe so an err is never issued to a master that
  // has already withdrawn its request.
  assign wdt_hit  = own_stb && (wdt == {TO_W{1'b1}});

  // Counts consecutive cycles of an owned strobe with no termination. The
  // timeout cycle itself clears the counter so the next beat starts fresh.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wdt <= '0;
    end else if (own_stb && !any_term && !wdt_hit) begin
      wdt <= wdt + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      wdt <= '0;
    end
  end

  // Forward path: the owner's request goes straight to the slave. On the
  // timeout cycle cyc/stb are withdrawn so the slave drops the stuck access.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    unique case (state)
      GNT0: begin
        s_cyc_o = m0_cyc_i && !wdt_hit;
        s_stb_o = m0_stb_i && !wdt_hit;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i && !wdt_hit;
        s_stb_o = m1_stb_i && !wdt_hit;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  // Return path: read data is shared, terminations reach the owner only.
  // A timeout turns the cycle into an err and masks a coincident late ack.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign m0_ack_o = (state == GNT0) && s_ack_i && !wdt_hit;
  assign m0_err_o = (state == GNT0) && (s_err_i || wdt_hit);
  assign m0_rty_o = (state == GNT0) && s_rty_i;

  assign m1_ack_o = (state == GNT1) && s_ack_i && !wdt_hit;
  assign m1_err_o = (state == GNT1) && (s_err_i || wdt_hit);
  assign m1_rty_o = (state == GNT1) && s_rty_i;

endmodule
